// File: rtl/dequant_recon4.sv
// dequant_recon4: 4x4 dequantize, two-pass integer inverse DCT, add prediction, clip to 8 bits; one row/column per cycle.
// start->done 10 cycles (2 for DC-only blocks when DC_ONLY_EN is defined); start ignored unless idle, no backpressure.
module dequant_recon4 #(
   parameter int BLOCK_SIZE = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [255:0] levels,
   input  logic [255:0] iq,
   input  logic [127:0] pred,
   output logic [127:0] out,
   output logic         nz,
   output logic         busy,
   output logic         done
);
   localparam int N = BLOCK_SIZE * BLOCK_SIZE;

   typedef enum logic [3:0] {IDLE, DEQ, VP0, VP1, VP2, VP3, HP0, HP1, HP2, HP3, DONE} state_t;
   state_t state, state_nxt;

   logic [255:0]       lv_q, iq_q;
   logic [127:0]       pred_q;
   logic               nz_q;
   logic signed [15:0] c     [N];
   logic signed [15:0] c_nxt [N];
   logic signed [17:0] t     [N];
   logic [95:0]        rows_q;
   logic               vp, hp;
   logic [1:0]         idx;
   logic signed [21:0] bx [4];
   logic signed [21:0] by [4];
   logic signed [21:0] x0, a, b, cc, d;
   logic [31:0]        row_pix;
`ifdef DC_ONLY_EN
   logic               dc_only_q;
   logic [127:0]       dc_pix;
`endif

   function automatic logic signed [21:0] mul1(input logic signed [21:0] x);
      return 22'((x * 44'sd20091) >>> 16) + x;
   endfunction

   function automatic logic signed [21:0] mul2(input logic signed [21:0] x);
      return 22'((x * 44'sd35468) >>> 16);
   endfunction

   function automatic logic signed [15:0] dq(input logic [15:0] lv, input logic [15:0] q);
      logic signed [32:0] p;
      p = $signed(lv) * $signed({1'b0, q});
      if (p > 33'sd32767)       return 16'sh7fff;
      else if (p < -33'sd32768) return 16'sh8000;
      else                      return p[15:0];
   endfunction

   // v is the unscaled second-pass value; the >>>3 rounding shift lives here
   function automatic logic [7:0] pix8(input logic [7:0] p, input logic signed [21:0] v);
      logic signed [21:0] s;
      s = $signed({14'b0, p}) + (v >>> 3);
      if (s < 22'sd0)        return 8'd0;
      else if (s > 22'sd255) return 8'd255;
      else                   return s[7:0];
   endfunction

   always_comb begin
      for (int i = 0; i < N; i++) begin
         c_nxt[i] = dq(lv_q[16*i +: 16], iq_q[16*i +: 16]);
      end
   end

   // One butterfly shared by both passes: columns of c, then rows of t (with the +4 rounding bias)
   always_comb begin
      vp  = state inside {VP0, VP1, VP2, VP3};
      hp  = state inside {HP0, HP1, HP2, HP3};
      idx = 2'(state - VP0);
      for (int j = 0; j < 4; j++) begin
         bx[j] = hp ? 22'(t[{2'(j), idx}]) : 22'(c[{2'(j), idx}]);
      end
      x0 = bx[0] + (hp ? 22'sd4 : 22'sd0);
      a  = x0 + bx[2];
      b  = x0 - bx[2];
      cc = mul2(bx[1]) - mul1(bx[3]);
      d  = mul1(bx[1]) + mul2(bx[3]);
      by[0] = a + d;
      by[1] = b + cc;
      by[2] = b - cc;
      by[3] = a - d;
      for (int j = 0; j < 4; j++) begin
         row_pix[8*j +: 8] = pix8(pred_q[{idx, 2'(j), 3'b000} +: 8], by[j]);
      end
   end

`ifdef DC_ONLY_EN
   always_comb begin
      for (int i = 0; i < N; i++) begin
         dc_pix[8*i +: 8] = pix8(pred_q[8*i +: 8], 22'(c_nxt[0]) + 22'sd4);
      end
   end
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = DEQ;
         DEQ: begin
`ifdef DC_ONLY_EN
            state_nxt = dc_only_q ? DONE : VP0;
`else
            state_nxt = VP0;
`endif
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = state_t'(state + 4'd1);
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         lv_q   <= levels;
         iq_q   <= iq;
         pred_q <= pred;
         nz_q   <= |levels;
`ifdef DC_ONLY_EN
         dc_only_q <= ~|levels[255:16];
`endif
      end
      if (state == DEQ) c <= c_nxt;
      if (vp) begin
         for (int j = 0; j < 4; j++) begin
            t[{idx, 2'(j)}] <= 18'(by[j]);
         end
      end
      case (state)
         HP0:     rows_q[31:0]  <= row_pix;
         HP1:     rows_q[63:32] <= row_pix;
         HP2:     rows_q[95:64] <= row_pix;
         default: ;
      endcase
   end

   // out/nz change only on entry to DONE so downstream never sees a partial block
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         out   <= '0;
         nz    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == HP3) begin
            out <= {row_pix, rows_q};
            nz  <= nz_q;
         end
`ifdef DC_ONLY_EN
         if (state == DEQ && dc_only_q) begin
            out <= dc_pix;
            nz  <= nz_q;
         end
`endif
      end
   end
endmodule

// File: tb/tb_dequant_recon4.sv
// Bench for dequant_recon4: vector table, busy/reset/DONE-cycle corner sequences, back-to-back random blocks.
module tb_dequant_recon4;
   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [255:0] levels, iq;
   logic [127:0] pred;
   logic [127:0] out;
   logic         nz, busy, done;

   int n_vec = 0;
   int n_mis = 0;
   int cyc = 0;

   typedef struct {
      logic [127:0] px;
      logic         nz;
      int           due;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [255:0] lv;
      logic [255:0] q;
      logic [127:0] pr;
      logic [127:0] px;
      logic         nz;
   } vec_t;

   dequant_recon4 dut (
      .clk(clk), .rst(rst), .start(start), .levels(levels), .iq(iq), .pred(pred),
      .out(out), .nz(nz), .busy(busy), .done(done)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic longint m1(input longint x);
      return ((x * 20091) >>> 16) + x;
   endfunction
   function automatic longint m2(input longint x);
      return (x * 35468) >>> 16;
   endfunction
   function automatic logic [7:0] clipl(input longint v);
      return (v < 0) ? 8'd0 : (v > 255) ? 8'd255 : 8'(v);
   endfunction

   // Plain reference: saturating dequant, column pass, row pass, add prediction
   function automatic void ref_model(input logic [255:0] lv, input logic [255:0] q, input logic [127:0] pr,
                                     output logic [127:0] px, output logic nzo);
      longint c[16], t[16], p, a, b, cc, d, dc, v[4];
      nzo = (lv != '0);
      for (int i = 0; i < 16; i++) begin
         p = longint'($signed(lv[16*i +: 16])) * longint'(q[16*i +: 16]);
         c[i] = (p > 32767) ? 32767 : (p < -32768) ? -32768 : p;
      end
      for (int k = 0; k < 4; k++) begin
         a  = c[k] + c[8+k];
         b  = c[k] - c[8+k];
         cc = m2(c[4+k]) - m1(c[12+k]);
         d  = m1(c[4+k]) + m2(c[12+k]);
         t[4*k+0] = a + d;  t[4*k+1] = b + cc;
         t[4*k+2] = b - cc; t[4*k+3] = a - d;
      end
      for (int r = 0; r < 4; r++) begin
         dc = t[r] + 4;
         a  = dc + t[8+r];
         b  = dc - t[8+r];
         cc = m2(t[4+r]) - m1(t[12+r]);
         d  = m1(t[4+r]) + m2(t[12+r]);
         v[0] = a + d; v[1] = b + cc; v[2] = b - cc; v[3] = a - d;
         for (int col = 0; col < 4; col++)
            px[8*(4*r+col) +: 8] = clipl(longint'(pr[8*(4*r+col) +: 8]) + (v[col] >>> 3));
      end
   endfunction

   function automatic int lat(input logic [255:0] lv);
`ifdef DC_ONLY_EN
      return (lv[255:16] == '0) ? 2 : 10;
`else
      return (lv == lv) ? 10 : 10;
`endif
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      n_vec++;
      if (act !== req) begin
         n_mis++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go_raw(input logic [255:0] lv, input logic [255:0] q, input logic [127:0] pr);
      levels = lv; iq = q; pred = pr; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic go(input logic [255:0] lv, input logic [255:0] q, input logic [127:0] pr,
                     input logic [127:0] px, input logic nzv);
      exp_t e;
      e.px = px; e.nz = nzv; e.due = cyc + lat(lv);
      sb.push_back(e);
      go_raw(lv, q, pr);
   endtask

   task automatic drain();
      for (int i = 0; i < 30; i++) begin
         if (sb.size() == 0) break;
         step();
      end
      step();
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            n_vec++; n_mis++;
            $display("FAIL unexpected_done: done=1 at cycle %0d, required 0", cyc);
         end else begin
            e = sb.pop_front();
            chk("done_cycle", cyc, e.due);
            chk("out", out, e.px);
            chk("nz", nz, e.nz);
         end
      end else if (sb.size() != 0 && cyc > sb[0].due) begin
         n_vec++; n_mis++;
         $display("FAIL done_timeout: no done by cycle %0d, required at %0d", cyc, sb[0].due);
         void'(sb.pop_front());
      end
   end

   initial begin
      vec_t         tv[8];
      logic [255:0] lv, q;
      logic [127:0] pr, px;
      logic         nzr;
      bit           dco;
      int           lvl;

      for (int i = 0; i < 8; i++) begin
         tv[i].lv = '0; tv[i].q = {16{16'd1}}; tv[i].pr = '0; tv[i].px = '0; tv[i].nz = 1'b1;
      end
      tv[0].pr = {16{8'd128}}; tv[0].px = {16{8'd128}}; tv[0].nz = 1'b0;
      tv[1].lv[15:0] = 16'd10;     tv[1].q[15:0] = 16'd8; tv[1].pr = {16{8'd100}}; tv[1].px = {16{8'd110}};
      tv[2].lv[15:0] = 16'd20;     tv[2].q[15:0] = 16'd8; tv[2].pr = {16{8'd250}}; tv[2].px = {16{8'd255}};
      tv[3].lv[15:0] = 16'hFFF6;   tv[3].q[15:0] = 16'd8; tv[3].pr = {16{8'd5}};   tv[3].px = {16{8'd0}};
      tv[4].lv[80 +: 16] = 16'hF800; tv[4].q[80 +: 16] = 16'hFFFF; tv[4].pr = {16{8'd128}};
      tv[5].lv[48 +: 16] = 16'd7;  tv[5].q[48 +: 16] = 16'd0;
      for (int i = 0; i < 16; i++) tv[5].pr[8*i +: 8] = 8'(i * 13 + 20);
      tv[5].px = tv[5].pr;
      tv[6].lv[15:0] = 16'h07FF;   tv[6].q[15:0] = 16'hFFFF; tv[6].px = {16{8'd255}};
      for (int i = 0; i < 16; i++) begin
         tv[7].lv[16*i +: 16] = 16'(i * 37 - 200);
         tv[7].q[16*i +: 16]  = 16'(i + 3);
         tv[7].pr[8*i +: 8]   = 8'(i * 9 + 60);
      end
      ref_model(tv[4].lv, tv[4].q, tv[4].pr, px, nzr); tv[4].px = px; tv[4].nz = nzr;
      ref_model(tv[7].lv, tv[7].q, tv[7].pr, px, nzr); tv[7].px = px; tv[7].nz = nzr;

      rst = 1'b1; start = 1'b0; levels = '0; iq = '0; pred = '0;
      repeat (3) step();
      rst = 1'b0;
      chk("rst_out", out, 128'd0);
      chk("rst_nz", nz, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);

      for (int i = 0; i < 8; i++) begin
         go(tv[i].lv, tv[i].q, tv[i].pr, tv[i].px, tv[i].nz);
         drain();
      end

      // start while busy must be ignored and its inputs not latched
      go(tv[7].lv, tv[7].q, tv[7].pr, tv[7].px, tv[7].nz);
      repeat (2) step();
      chk("busy_mid", busy, 1'b1);
      go_raw(tv[4].lv, tv[4].q, tv[4].pr);
      drain();

      // start during the DONE cycle must be ignored
      go(tv[7].lv, tv[7].q, tv[7].pr, tv[7].px, tv[7].nz);
      repeat (9) step();
      go_raw(tv[4].lv, tv[4].q, tv[4].pr);
      chk("busy_after_done_start", busy, 1'b0);
      repeat (12) step();

      // reset mid-block aborts it
      go_raw(tv[7].lv, tv[7].q, tv[7].pr);
      repeat (4) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_busy", busy, 1'b0);
      chk("abort_out", out, 128'd0);
      chk("abort_done", done, 1'b0);
      repeat (12) step();

      for (int n = 0; n < 400; n++) begin
         dco = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < 16; i++) begin
            lvl = (dco && i != 0) ? 0 : int'($urandom_range(0, 4094)) - 2047;
            lv[16*i +: 16] = 16'(lvl);
            q[16*i +: 16]  = 16'($urandom_range(1, 157));
            pr[8*i +: 8]   = 8'($urandom_range(0, 255));
         end
         ref_model(lv, q, pr, px, nzr);
         go(lv, q, pr, px, nzr);
         repeat (10) step();
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
